// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA bus layout, count width and default 1024x768@60 timing constants.
// Bus field order, MSB to LSB: hcount, vcount, hs, vs, hblnk, vblnk, rgb.
package vga_timing_gen_pkg;

    localparam int unsigned COUNT_W   = 12;
    localparam int unsigned COUNT_MAX = 4096;

    localparam int unsigned VGA_BUS_SIZE   = 40;
    localparam int unsigned VGA_RGB_LSB    = 0;
    localparam int unsigned VGA_VBLNK_BIT  = 12;
    localparam int unsigned VGA_HBLNK_BIT  = 13;
    localparam int unsigned VGA_VS_BIT     = 14;
    localparam int unsigned VGA_HS_BIT     = 15;
    localparam int unsigned VGA_VCOUNT_LSB = 16;
    localparam int unsigned VGA_HCOUNT_LSB = 28;

    localparam int unsigned VGA_H_ACTIVE = 1024;
    localparam int unsigned VGA_H_FP     = 24;
    localparam int unsigned VGA_H_SYNC   = 136;
    localparam int unsigned VGA_H_BP     = 160;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 768;
    localparam int unsigned VGA_V_FP     = 3;
    localparam int unsigned VGA_V_SYNC   = 6;
    localparam int unsigned VGA_V_BP     = 29;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [COUNT_W-1:0] count_t;

    // Packed view of the bus; field order matches the offsets above.
    typedef struct packed {
        count_t      hcount;
        count_t      vcount;
        logic        hs;
        logic        vs;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MODULUS counter with increment enable. count is the registered value,
// count_next is the value it takes on the next edge (used for look-ahead decode),
// and wrap flags the edge on which count returns to zero.
module vga_wrap_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned MODULUS = VGA_H_TOTAL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    output count_t count,
    output count_t count_next,
    output logic   wrap
);

    localparam count_t LAST = count_t'(MODULUS - 1);

    // Next value: hold, increment, or wrap back to zero at the last position.
    always_comb begin
        wrap       = inc && (count == LAST);
        count_next = count;
        if (inc) begin
            count_next = wrap ? '0 : count + count_t'(1);
        end
    end

    // Count register; reset returns to zero from any position.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator. Horizontal and vertical counters
// plus registered sync/blank flags, packed onto the shared VGA bus. Flags are
// decoded from the counters' next values so every field describes one pixel.
// Optional frame_start pulse is enabled by defining VGA_TIMING_FRAME_PULSE_EN.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [VGA_BUS_SIZE-1:0] vga_out
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    output logic                    frame_start
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end

    localparam count_t H_BLANK_START = count_t'(H_ACTIVE);
    localparam count_t H_SYNC_START  = count_t'(H_ACTIVE + H_FP);
    localparam count_t H_SYNC_END    = count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam count_t V_BLANK_START = count_t'(V_ACTIVE);
    localparam count_t V_SYNC_START  = count_t'(V_ACTIVE + V_FP);
    localparam count_t V_SYNC_END    = count_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    count_t h_count, h_next, v_count, v_next;
    logic   h_wrap, v_wrap;
    logic   hs_q, vs_q, hblnk_q, vblnk_q;
    logic   hs_d, vs_d, hblnk_d, vblnk_d;

    vga_wrap_counter #(
        .MODULUS (H_TOTAL)
    ) u_hcnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (1'b1),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_wrap_counter #(
        .MODULUS (V_TOTAL)
    ) u_vcnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (h_wrap),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Sync/blank decode of the pixel the counters move to on this edge.
    always_comb begin
        hblnk_d = (h_next >= H_BLANK_START);
        hs_d    = (h_next >= H_SYNC_START) && (h_next <= H_SYNC_END);
        vblnk_d = (v_next >= V_BLANK_START);
        vs_d    = (v_next >= V_SYNC_START) && (v_next <= V_SYNC_END);
    end

    // Flag registers, cleared together with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hblnk_q <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hblnk_q <= hblnk_d;
            vblnk_q <= vblnk_d;
        end
    end

    // Bus packing; rgb is left black for downstream stages to paint.
    always_comb begin
        vga_bus_t bus;
        bus.hcount = h_count;
        bus.vcount = v_count;
        bus.hs     = hs_q;
        bus.vs     = vs_q;
        bus.hblnk  = hblnk_q;
        bus.vblnk  = vblnk_q;
        bus.rgb    = 12'h000;
        vga_out    = bus;
    end

`ifdef VGA_TIMING_FRAME_PULSE_EN
    logic frame_start_q;

    // Pulse when the bus moves to (0,0) by wrapping; the reset state itself does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= h_wrap && v_wrap;
        end
    end

    assign frame_start = frame_start_q;
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 1024x768 mode for horizontal decode
// and mid-line reset, a tiny mode (23x13) for vertical decode and frame wrap,
// and 640x480 for horizontal decode with non-default parameters.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [VGA_BUS_SIZE-1:0] bus_def, bus_small, bus_640;
`ifdef VGA_TIMING_FRAME_PULSE_EN
    logic fs_def, fs_small, fs_640;
`endif

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TIMING_FRAME_PULSE_EN
        .frame_start (fs_def),
`endif
        .vga_out     (bus_def)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_small (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TIMING_FRAME_PULSE_EN
        .frame_start (fs_small),
`endif
        .vga_out     (bus_small)
    );

    vga_timing_gen #(
        .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
        .V_ACTIVE (480), .V_FP (10), .V_SYNC (2),  .V_BP (33)
    ) u_640 (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TIMING_FRAME_PULSE_EN
        .frame_start (fs_640),
`endif
        .vga_out     (bus_640)
    );

    int n_checks = 0;
    int n_fail   = 0;

    vga_bus_t d, s, g, pd, ps, pg;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample all buses on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        pd = d;
        ps = s;
        pg = g;
        d  = vga_bus_t'(bus_def);
        s  = vga_bus_t'(bus_small);
        g  = vga_bus_t'(bus_640);
    endtask

    initial begin
        int d_hblnk_rise = -1, d_hs_first = -1, d_hs_last = -1, d_hs_len = 0;
        int d_wrap_h = -1, d_wrap_v = -1, d_wrap_hblnk = -1;
        int s_vblnk_rise = -1, s_vs_first = -1, s_vs_last = -1, s_vs_cycles = 0;
        int s_frames = 0, s_k1 = -1, s_k2 = -1;
        int s_wrap_ph = -1, s_wrap_pv = -1, s_wrap_vs = -1, s_wrap_vblnk = -1;
        int g_hs_first = -1, g_hs_last = -1, g_wrap_h = -1, g_wrap_v = -1;
        int fs_small_pulses = 0, fs_def_pulses = 0, fs_at_origin = -1;
        bit found;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        d = vga_bus_t'(bus_def);
        s = vga_bus_t'(bus_small);
        g = vga_bus_t'(bus_640);
        check_eq("rst_hcount", 32'(d.hcount), 0);
        check_eq("rst_vcount", 32'(d.vcount), 0);
        check_eq("rst_hs",     32'(d.hs), 0);
        check_eq("rst_vs",     32'(d.vs), 0);
        check_eq("rst_hblnk",  32'(d.hblnk), 0);
        check_eq("rst_vblnk",  32'(d.vblnk), 0);
        check_eq("rst_rgb",    32'(d.rgb), 0);
        check_eq("rst_small_hv", {8'h0, s.hcount, s.vcount}, 0);
`ifdef VGA_TIMING_FRAME_PULSE_EN
        check_eq("rst_frame_start", 32'({fs_def, fs_small}), 0);
`endif

        rst = 1'b0;
        tick();
        check_eq("first_hcount", 32'(d.hcount), 1);
        check_eq("first_vcount", 32'(d.vcount), 0);
        check_eq("first_small_hcount", 32'(s.hcount), 1);
`ifdef VGA_TIMING_FRAME_PULSE_EN
        check_eq("first_frame_start", 32'(fs_small), 0);
`endif

        for (int k = 2; k <= 1400; k++) begin
            tick();
            // Default mode: horizontal edges on line 0 and the first line wrap.
            if (!pd.hblnk && d.hblnk && d_hblnk_rise < 0) d_hblnk_rise = int'(d.hcount);
            if (d.vcount == 0 && d.hs) begin
                if (d_hs_first < 0) d_hs_first = int'(d.hcount);
                d_hs_len++;
            end
            if (pd.hs && !d.hs && d_hs_last < 0) d_hs_last = int'(pd.hcount);
            if (pd.hcount == 1343 && d_wrap_v < 0) begin
                d_wrap_h     = int'(d.hcount);
                d_wrap_v     = int'(d.vcount);
                d_wrap_hblnk = int'(d.hblnk);
            end
            // Tiny mode: vertical edges, frame period and frame wrap.
            if (!ps.vblnk && s.vblnk && s_vblnk_rise < 0) s_vblnk_rise = int'(s.vcount);
            if (s.vs && s_vs_first < 0) s_vs_first = int'(s.vcount);
            if (ps.vs && !s.vs && s_vs_last < 0) s_vs_last = int'(ps.vcount);
            if (s_frames == 1 && s.vs) s_vs_cycles++;
            if (s.hcount == 0 && s.vcount == 0) begin
                s_frames++;
                if (s_frames == 1) begin
                    s_k1         = k;
                    s_wrap_ph    = int'(ps.hcount);
                    s_wrap_pv    = int'(ps.vcount);
                    s_wrap_vs    = int'(s.vs);
                    s_wrap_vblnk = int'(s.vblnk);
`ifdef VGA_TIMING_FRAME_PULSE_EN
                    fs_at_origin = int'(fs_small);
`endif
                end
                if (s_frames == 2) s_k2 = k;
            end
`ifdef VGA_TIMING_FRAME_PULSE_EN
            if (fs_small) fs_small_pulses++;
            if (fs_def) fs_def_pulses++;
`endif
            // 640x480 mode: horizontal edges and line length.
            if (g.vcount == 0 && g.hs && g_hs_first < 0) g_hs_first = int'(g.hcount);
            if (pg.hs && !g.hs && g_hs_last < 0) g_hs_last = int'(pg.hcount);
            if (pg.hcount == 799 && g_wrap_v < 0) begin
                g_wrap_h = int'(g.hcount);
                g_wrap_v = int'(g.vcount);
            end
        end

        check_eq("h_hblnk_rise", d_hblnk_rise, 1024);
        check_eq("h_hs_first",   d_hs_first, 1048);
        check_eq("h_hs_last",    d_hs_last, 1183);
        check_eq("h_hs_len",     d_hs_len, 136);
        check_eq("h_wrap_hcount", d_wrap_h, 0);
        check_eq("h_wrap_vcount", d_wrap_v, 1);
        check_eq("h_wrap_hblnk",  d_wrap_hblnk, 0);

        check_eq("v_vblnk_rise", s_vblnk_rise, 8);
        check_eq("v_vs_first",   s_vs_first, 9);
        check_eq("v_vs_last",    s_vs_last, 10);
        check_eq("v_vs_cycles",  s_vs_cycles, 46);
        check_eq("frame_first_k", s_k1, 299);
        check_eq("frame_period", s_k2 - s_k1, 299);
        check_eq("frame_count",  s_frames, 4);
        check_eq("fwrap_prev_h", s_wrap_ph, 22);
        check_eq("fwrap_prev_v", s_wrap_pv, 12);
        check_eq("fwrap_vs",     s_wrap_vs, 0);
        check_eq("fwrap_vblnk",  s_wrap_vblnk, 0);

        check_eq("m640_hs_first", g_hs_first, 656);
        check_eq("m640_hs_last",  g_hs_last, 751);
        check_eq("m640_wrap_h",   g_wrap_h, 0);
        check_eq("m640_wrap_v",   g_wrap_v, 1);

`ifdef VGA_TIMING_FRAME_PULSE_EN
        check_eq("fs_at_origin",    fs_at_origin, 1);
        check_eq("fs_small_pulses", fs_small_pulses, 4);
        check_eq("fs_def_pulses",   fs_def_pulses, 0);
`endif

        // Mid-line reset while default mode is in blanking and sync.
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            if (d.hcount == 1100) found = 1'b1;
            else tick();
        end
        check_eq("mid_rst_reached", 32'(found), 1);
        if (found) begin
            check_eq("mid_pre_hs",    32'(d.hs), 1);
            check_eq("mid_pre_hblnk", 32'(d.hblnk), 1);
            rst = 1'b1;
            tick();
            check_eq("mid_rst_hcount", 32'(d.hcount), 0);
            check_eq("mid_rst_vcount", 32'(d.vcount), 0);
            check_eq("mid_rst_flags", 32'({d.hs, d.vs, d.hblnk, d.vblnk}), 0);
            check_eq("mid_rst_small_hv", {8'h0, s.hcount, s.vcount}, 0);
`ifdef VGA_TIMING_FRAME_PULSE_EN
            check_eq("mid_rst_fs", 32'(fs_def), 0);
`endif
            rst = 1'b0;
            tick();
            check_eq("mid_resume_hcount", 32'(d.hcount), 1);
            check_eq("mid_resume_vcount", 32'(d.vcount), 0);
            check_eq("mid_resume_hblnk",  32'(d.hblnk), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator; first stage of the video pipeline.
- Produces horizontal and vertical pixel counters, sync pulses and blanking flags.
- Packs them onto the shared VGA bus consumed directly by vga_draw_background.
- Default mode is 1024x768 @ 60 Hz with a 65 MHz clk (one pixel per clk).

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels); line total H_TOTAL = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); frame total V_TOTAL = 806

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- vga_out  out  VGA_BUS_SIZE  packed bus: hcount 12, vcount 12, hs 1, vs 1, hblnk 1, vblnk 1, rgb 12; field order per shared VGA macro header
- frame_start  out  1  only with VGA_TIMING_FRAME_PULSE_EN

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- All bus fields are registers with no combinational path to outputs.
- Each field is computed from the next counter value, so all fields describe the same pixel in the same cycle.
- Reset values:
  - hcount = 0, vcount = 0.
  - hs = 0, vs = 0, hblnk = 0, vblnk = 0.
  - rgb = 12'h000.
  - frame_start = 0.
  - First post-reset cycle presents pixel (1,0).
- Horizontal counter: +1 per clk; at H_TOTAL-1 it wraps to 0.
- Vertical counter: +1 only on the clk where hcount wraps; at V_TOTAL-1 it wraps to 0, simultaneously with hcount wrap.
- hblnk = 1 iff hcount >= H_ACTIVE.
- hs = 1 iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1.
- vblnk = 1 iff vcount >= V_ACTIVE.
- vs = 1 iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1.
- hs/vs are active-high internally; pin polarity is applied at the top level.
- rgb field is constant 12'h000; downstream stages paint it.
- Widths:
  - Counters are 12-bit unsigned.
  - H_TOTAL and V_TOTAL must be <= 4096; elaboration-time check stops the build otherwise.
  - Comparisons are unsigned; no other arithmetic.
- Wrap: hcount=1343 -> 0, with vcount+1 on the same edge. At vcount=805, that edge also returns vcount to 0.
- Reset mid-frame: counters return to 0 on the next edge regardless of position; no partial-line completion.
- Sync/blank outputs drop to 0 with the reset.
- The block has no stall or enable; a downstream latency of N stages is compensated downstream, not here.

Optional Feature:
- Macro: VGA_TIMING_FRAME_PULSE_EN.
- Defined: frame_start port exists and is registered.
  - High for exactly one clk when the bus presents hcount=0, vcount=0.
  - Not asserted during reset.
  - Asserted on the first wrap to (0,0) after reset, not for the reset state itself.
- Undefined: port absent; no logic generated.

Decomposition:
- Shared header/package holds:
  - VGA_BUS_SIZE and the bus field offsets.
  - The default timing constants for 1024x768@60 (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL).
  - The 12-bit count width.
- One sub-module: vga_wrap_counter.
  - Parameterised modulus.
  - Inputs: clk, rst, inc.
  - Outputs: count, wrap.
  - Instantiated twice: horizontal with inc=1; vertical with inc = horizontal wrap.
- Decode of sync/blank is local to vga_timing_gen.

Test Plan:
- Reset held 5 clks, then released:
  - During reset, bus hcount=0, vcount=0, hs=vs=hblnk=vblnk=0, rgb=0.
  - First cycle after release, hcount=1, vcount=0.
- Horizontal decode over one line:
  - hblnk rises at hcount=1024.
  - hs high for hcount 1048..1183 (136 clks).
  - Wrap 1343->0 with vcount 0->1.
- Vertical decode over one frame:
  - vblnk rises at vcount=768.
  - vs high for vcount 771..776 (6 lines = 8064 clks).
  - Frame period exactly 1344*806 = 1083264 clks.
- Frame wrap: at (1343,805) next cycle is (0,0) with vs=0, vblnk=0.
  - With VGA_TIMING_FRAME_PULSE_EN, frame_start=1 for that single cycle only.
- Reset asserted at (500,300) for 1 clk: next cycle bus is (0,0) all flags 0, then counting resumes from (1,0).
- Non-default parameters 640x480 (H 640/16/96/48, V 480/10/2/33): hs at 656..751, vs at 490..491, line 800, frame 525 lines.
